// File: rtl/chunk_serial_adder.sv
// ----------------------------------------------------------------------------
// chunk_serial_adder
//   Multi-cycle adder: sum = a + b + c_in (mod 2^WIDTH), processed CHUNK bits
//   per clock with the inter-chunk carry held in a register. An operation
//   takes N = WIDTH/CHUNK ADD cycles after the start edge.
//
// Parameters
//   WIDTH  operand / sum width (multiple of CHUNK)
//   CHUNK  bits added per clock
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      operation request, sampled only while idle
//   a, b   in   WIDTH  operands (latched on the accepting edge)
//   c_in   in   1      carry into bit 0
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse: sum/c_out/ovf just updated
//   sum    out  WIDTH  result, held until the next completion
//   c_out  out  1      carry out of bit WIDTH-1
//   ovf    out  1      signed overflow (carry into MSB ^ carry out of MSB)
// ----------------------------------------------------------------------------
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  // One chunk of ripple addition; bit CHUNK of the result is the carry-out.
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  state_t           state_r,  state_nx_s;
  logic [WIDTH-1:0] a_r,      a_nx_s;
  logic [WIDTH-1:0] b_r,      b_nx_s;
  logic             carry_r,  carry_nx_s;
  logic [IDXW-1:0]  idx_r,    idx_nx_s;
  logic [WIDTH-1:0] psum_r,   psum_nx_s;
  logic             busy_nx_s;
  logic             done_nx_s;
  logic [WIDTH-1:0] sum_nx_s;
  logic             c_out_nx_s;
  logic             ovf_nx_s;

  logic [CHUNK-1:0] chunk_a_s;
  logic [CHUNK-1:0] chunk_b_s;
  logic [CHUNK:0]   chunk_res_s;

  // Select the current chunk of both latched operands and add it with the carry.
  always_comb begin
    chunk_a_s   = a_r[int'(idx_r)*CHUNK +: CHUNK];
    chunk_b_s   = b_r[int'(idx_r)*CHUNK +: CHUNK];
    chunk_res_s = chunk_add(chunk_a_s, chunk_b_s, carry_r);
  end

  // Next-state and next-output logic for the IDLE/ADD controller.
  always_comb begin
    state_nx_s = state_r;
    a_nx_s     = a_r;
    b_nx_s     = b_r;
    carry_nx_s = carry_r;
    idx_nx_s   = idx_r;
    psum_nx_s  = psum_r;
    busy_nx_s  = busy;
    done_nx_s  = 1'b0;
    sum_nx_s   = sum;
    c_out_nx_s = c_out;
    ovf_nx_s   = ovf;

    case (state_r)
      IDLE: begin
        if (start) begin
          a_nx_s     = a;
          b_nx_s     = b;
          carry_nx_s = c_in;
          idx_nx_s   = '0;
          busy_nx_s  = 1'b1;
          state_nx_s = ADD;
        end else begin
          busy_nx_s  = 1'b0;
        end
      end

      ADD: begin
        psum_nx_s[int'(idx_r)*CHUNK +: CHUNK] = chunk_res_s[CHUNK-1:0];
        carry_nx_s = chunk_res_s[CHUNK];
        idx_nx_s   = idx_r + IDXW'(1);
        if (idx_r == IDX_LAST) begin
          sum_nx_s   = psum_nx_s;
          c_out_nx_s = chunk_res_s[CHUNK];
          // Carry into the MSB is recovered as a^b^sum at that bit.
          ovf_nx_s   = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ psum_nx_s[WIDTH-1]
                       ^ chunk_res_s[CHUNK];
          done_nx_s  = 1'b1;
          busy_nx_s  = 1'b0;
          idx_nx_s   = '0;
          state_nx_s = IDLE;
        end else begin
          busy_nx_s  = 1'b1;
        end
      end

      default: begin
        state_nx_s = IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      psum_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      a_r     <= a_nx_s;
      b_r     <= b_nx_s;
      carry_r <= carry_nx_s;
      idx_r   <= idx_nx_s;
      psum_r  <= psum_nx_s;
      busy    <= busy_nx_s;
      done    <= done_nx_s;
      sum     <= sum_nx_s;
      c_out   <= c_out_nx_s;
      ovf     <= ovf_nx_s;
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_chunk_serial_adder
//   Self-checking bench for chunk_serial_adder at WIDTH=16 with CHUNK=4, 16
//   and 1 (instances 0, 1, 2). Expected results come from a plain-arithmetic
//   reference of a+b+c_in with the signed-overflow sign rule.
// ----------------------------------------------------------------------------
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start;
  logic [15:0] a, b;
  logic        c_in;

  logic        busy0, done0, co0, ov0;
  logic [15:0] sum0;
  logic        busy1, done1, co1, ov1;
  logic [15:0] sum1;
  logic        busy2, done2, co2, ov2;
  logic [15:0] sum2;

  int checks   = 0;
  int failures = 0;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b), .c_in(c_in),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(co0), .ovf(ov0));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b), .c_in(c_in),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1), .ovf(ov1));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a), .b(b), .c_in(c_in),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(co2), .ovf(ov2));

  // Cycles per operation for each instance.
  function automatic int n_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Observation bundle: {busy, done, c_out, ovf, sum[15:0]}.
  function automatic logic [19:0] obs(input int sel);
    case (sel)
      0:       return {busy0, done0, co0, ov0, sum0};
      1:       return {busy1, done1, co1, ov1, sum1};
      default: return {busy2, done2, co2, ov2, sum2};
    endcase
  endfunction

  // Reference: {c_out, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    int unsigned t;
    logic [15:0] s;
    logic        co, ov;
    t  = 32'(x) + 32'(y) + 32'(ci);
    s  = t[15:0];
    co = (t > 32'd65535);
    ov = (x[15] == y[15]) && (s[15] != x[15]);
    return {co, ov, s};
  endfunction

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic do_op(input int sel, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, output logic [19:0] res, output int lat,
                       output int busy_cnt, output bit held);
    logic [19:0] r;
    logic [15:0] prev;
    @(posedge clk); #1;
    a = x; b = y; c_in = ci; start[sel] = 1'b1;
    r = obs(sel);
    prev = r[15:0];
    @(posedge clk); #1;
    start[sel] = 1'b0;
    lat = 0; busy_cnt = 0; held = 1'b1;
    r = obs(sel);
    if (r[19]) busy_cnt++;
    if (r[15:0] !== prev) held = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      r = obs(sel);
      if (r[18]) break;
      if (r[19]) busy_cnt++;
      if (r[15:0] !== prev) held = 1'b0;
    end
    res = r;
  endtask

  task automatic test_reset();
    logic [19:0] r;
    rst = 1'b1; start = 3'b000; a = 16'h0000; b = 16'h0000; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      r = obs(s);
      checks++;
      if (r !== 20'h00000) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", s, r, 20'h00000);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'h0003, 16'hFFFF, 16'h0007, 16'h7FFF, 16'h8000};
    logic [15:0] vb [5] = '{16'h0005, 16'h0001, 16'h0009, 16'h0001, 16'h8000};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [17:0] ve [5] = '{{1'b0, 1'b0, 16'h0008}, {1'b1, 1'b0, 16'h0000},
                            {1'b0, 1'b0, 16'h0011}, {1'b0, 1'b1, 16'h8000},
                            {1'b1, 1'b1, 16'h0000}};
    logic [19:0] res;
    int lat, bc;
    bit held;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 5; i++) begin
        do_op(s, va[i], vb[i], vc[i], res, lat, bc, held);
        checks++;
        if (res[17:0] !== ve[i]) begin
          failures++;
          $display("FAIL vector_result dut%0d v%0d got=%h exp=%h", s, i, res[17:0], ve[i]);
        end
        checks++;
        if (lat !== n_of(s)) begin
          failures++;
          $display("FAIL vector_latency dut%0d v%0d got=%0d exp=%0d", s, i, lat, n_of(s));
        end
        checks++;
        if (bc !== n_of(s) || res[19] !== 1'b0) begin
          failures++;
          $display("FAIL vector_busy dut%0d v%0d busy_cycles=%0d busy_at_done=%b exp=%0d,0",
                   s, i, bc, res[19], n_of(s));
        end
        checks++;
        if (held !== 1'b1) begin
          failures++;
          $display("FAIL vector_sum_held dut%0d v%0d got=%b exp=1", s, i, held);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int e, cnt, first_e;
    logic [15:0] s_seen;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
    e = 0; cnt = 0; first_e = -1; s_seen = 16'h0000;
    @(posedge clk); #1; e++;
    if (done0) begin cnt++; first_e = e; s_seen = sum0; end
    start[0] = 1'b1;
    @(posedge clk); #1; e++;
    start[0] = 1'b0;
    if (done0) begin cnt++; first_e = e; s_seen = sum0; end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; e++;
      if (done0) begin
        cnt++;
        if (first_e < 0) begin first_e = e; s_seen = sum0; end
      end
    end
    checks++;
    if (cnt !== 1) begin
      failures++;
      $display("FAIL ignore_start_done_count got=%0d exp=1", cnt);
    end
    checks++;
    if (s_seen !== 16'h2345) begin
      failures++;
      $display("FAIL ignore_start_sum got=%h exp=%h", s_seen, 16'h2345);
    end
    checks++;
    if (first_e !== 4) begin
      failures++;
      $display("FAIL ignore_start_latency got=%0d exp=4", first_e);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    logic [19:0] res;
    int lat, bc;
    bit held;
    @(posedge clk); #1;
    a = 16'h00AA; b = 16'h0011; c_in = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b1 || sum0 === 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_precondition busy=%b sum=%h exp busy=1 sum!=0", busy0, sum0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy0, done0, co0, ov0, sum0} !== 20'h00000) begin
      failures++;
      $display("FAIL reset_mid_immediate got=%h exp=%h",
               {busy0, done0, co0, ov0, sum0}, 20'h00000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done0 || busy0) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d active cycles exp=0", dcnt);
    end
    do_op(0, 16'h000F, 16'h0001, 1'b0, res, lat, bc, held);
    checks++;
    if (res[15:0] !== 16'h0010 || lat !== 4) begin
      failures++;
      $display("FAIL reset_mid_fresh_op sum=%h lat=%0d exp sum=0010 lat=4", res[15:0], lat);
    end
  endtask

  task automatic test_back_to_back(input int sel);
    logic [17:0] expq [$];
    logic [17:0] e;
    logic [19:0] r;
    logic [15:0] x, y;
    logic        ci;
    int cnt, extra;
    @(posedge clk); #1;
    x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
    a = x; b = y; c_in = ci; start[sel] = 1'b1;
    expq.push_back(model(x, y, ci));
    for (int op = 0; op < 6; op++) begin
      cnt = 0;
      r = obs(sel);
      while (cnt < 100) begin
        @(posedge clk); #1;
        cnt++;
        r = obs(sel);
        if (r[18]) break;
      end
      if (op < 5) begin
        x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
        a = x; b = y; c_in = ci;
        expq.push_back(model(x, y, ci));
      end else begin
        start[sel] = 1'b0;
      end
      e = expq.pop_front();
      checks++;
      if (cnt !== n_of(sel) + 1) begin
        failures++;
        $display("FAIL b2b_spacing dut%0d op%0d got=%0d exp=%0d", sel, op, cnt, n_of(sel) + 1);
      end
      checks++;
      if (r[17:0] !== e) begin
        failures++;
        $display("FAIL b2b_result dut%0d op%0d got=%h exp=%h", sel, op, r[17:0], e);
      end
    end
    extra = 0;
    for (int i = 0; i < n_of(sel) + 4; i++) begin
      @(posedge clk); #1;
      r = obs(sel);
      if (r[18]) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL b2b_trailing_done dut%0d got=%0d exp=0", sel, extra);
    end
  endtask

  task automatic test_random();
    logic [19:0] res;
    logic [17:0] e;
    logic [15:0] x, y;
    logic        ci;
    int lat, bc, s;
    bit held;
    for (int i = 0; i < 1000; i++) begin
      s  = i % 3;
      x  = 16'($urandom);
      y  = 16'($urandom);
      ci = 1'($urandom);
      e  = model(x, y, ci);
      do_op(s, x, y, ci, res, lat, bc, held);
      checks++;
      if (res[17:0] !== e || lat !== n_of(s)) begin
        failures++;
        $display("FAIL random dut%0d a=%h b=%h cin=%b got=%h lat=%0d exp=%h lat=%0d",
                 s, x, y, ci, res[17:0], lat, e, n_of(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
